// File: rtl/bcd_ascii_tx.sv
// bcd_ascii_tx
//   Serialises a packed BCD/hex digit word as ASCII bytes toward a UART TX
//   byte engine, most-significant digit first, one byte per valid/ready
//   transfer.
//
// Optional feature macro: ASCII_CRLF_EN
//   defined   -> each frame is followed by CR (0x0D) and LF (0x0A)
//   undefined -> frame is exactly N_DIGITS bytes
//
// Parameters
//   N_DIGITS   digits per frame (1..8); digit k is i_digits[4k+3:4k]
//   HEX_UPPER  0: nibbles 10..15 -> 'a'..'f'; 1: -> 'A'..'F'
//
// Ports
//   i_clk       system clock, rising edge
//   i_rstn      asynchronous active-low reset
//   i_start     frame request, sampled only while idle
//   i_digits    digit word, captured when a frame starts
//   o_busy      frame in progress
//   o_done      one-cycle pulse after the last byte of a frame is accepted
//   o_tx_valid  o_tx_data holds a byte for the UART TX
//   o_tx_data   ASCII byte
//   i_tx_ready  UART TX accepts the byte this cycle
module bcd_ascii_tx #(
  parameter int N_DIGITS  = 4,
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [4*N_DIGITS-1:0] i_digits,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef ASCII_CRLF_EN
    ,
    EOL_CR,
    EOL_LF
`endif
  } state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      index_reg;
  logic [4*N_DIGITS-1:0] digits_reg;
  logic                  accept;

  assign accept = o_tx_valid & i_tx_ready;

  // Nibble to ASCII: 0..9 are decimal digits, 10..15 are hex letters.
  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] base;
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    base = HEX_UPPER ? 8'h41 : 8'h61;
    return base + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [3:0] digit_at(input logic [4*N_DIGITS-1:0] w,
                                          input logic [IDX_W-1:0]      k);
    logic [4*N_DIGITS-1:0] s;
    s = w >> {k, 2'b00};
    return s[3:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg  <= IDLE;
      index_reg  <= '0;
      digits_reg <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Also reached in the o_done cycle, so a new frame can follow
          // with no idle gap.
          if (i_start) begin
            digits_reg <= i_digits;
            index_reg  <= IDX_TOP;
            o_tx_data  <= enc(digit_at(i_digits, IDX_TOP));
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state_reg  <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (index_reg != '0) begin
              index_reg <= index_reg - 1'b1;
              o_tx_data <= enc(digit_at(digits_reg, index_reg - 1'b1));
            end else begin
`ifdef ASCII_CRLF_EN
              o_tx_data <= 8'h0D;
              state_reg <= EOL_CR;
`else
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              state_reg  <= IDLE;
`endif
            end
          end
        end
`ifdef ASCII_CRLF_EN
        EOL_CR: begin
          if (accept) begin
            o_tx_data <= 8'h0A;
            state_reg <= EOL_LF;
          end
        end
        EOL_LF: begin
          if (accept) begin
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            state_reg  <= IDLE;
          end
        end
`endif
        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule
